tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of byte requesters sharing the serial line (legal 1..8).
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (legal 2..65535).
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  per-requester send request, level, held until granted.
REQ-006 data  input  NUM_REQ*8  byte of requester i at bits [8i+7:8i], held stable while req[i] is high.
REQ-007 grant  output  NUM_REQ  one-hot, one-cycle pulse: byte of that requester accepted.
REQ-008 busy  output  1  high while a frame is being shifted out.
REQ-009 tx  output  1  serial line, registered, idles high.

Function
REQ-010 The block SHALL use states IDLE, START, DATA, STOP (PARITY added per REQ-027).
REQ-011 IDLE: tx=1, busy=0; on an edge where any req bit is high, SHALL select the winner, latch its byte, pulse grant for the following cycle, and enter START.
REQ-012 Arbitration SHALL be round-robin: search starts at the index after the last granted one, wrapping NUM_REQ-1 -> 0; after reset, index 0 has highest priority.
REQ-013 Exactly one grant bit SHALL be high per accepted byte; grant SHALL be 0 in all other cycles.
REQ-014 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-015 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, 3-bit bit index wraps 7 -> done, then STOP.
REQ-016 STOP: tx=1 for CLKS_PER_BIT cycles; at its last cycle, if any req is high, SHALL arbitrate per REQ-011/012 and enter START directly (no idle gap), else enter IDLE.
REQ-017 busy SHALL be 1 in START, DATA, STOP (and PARITY) and 0 in IDLE.
REQ-018 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity); first tx=0 cycle is the cycle after the accepting edge.
REQ-019 A req deasserted before its grant SHALL be dropped with no grant and no frame.
REQ-020 Requests arriving mid-frame SHALL be ignored until the STOP decision point; the latched byte SHALL not change mid-frame if data changes.
REQ-021 Bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, reload to 0 at each bit boundary.

Reset
REQ-022 On rst_n low, immediately: state=IDLE, tx=1, busy=0, grant=0, round-robin pointer such that index 0 wins next, counters 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no grant and no resumption; tx SHALL return high asynchronously.
REQ-024 After rst_n rises, the first arbitration SHALL occur no earlier than the first rising clk edge with rst_n high.

Configuration
REQ-025 Macro TX_ARBITER_PARITY_EN SHALL control the parity bit.
REQ-026 Undefined: 8N1 frames, no PARITY state, 10*CLKS_PER_BIT cycles per frame.
REQ-027 Defined: a PARITY state between DATA and STOP drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; 8E1, 11*CLKS_PER_BIT cycles per frame.

Verification (NUM_REQ=2, CLKS_PER_BIT=4, parity off unless stated)
REQ-028 Single request: req=01, data[7:0]=0xA5 -> grant=01 one cycle, tx sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles, busy high 40 cycles.
REQ-029 Contention: req=11 held, bytes 0x11/0x22 -> grants alternate 01,10,01,... frames back-to-back every 40 cycles, no idle tx between frames.
REQ-030 Withdrawal: req[1] pulsed high for 0 edges (rise and fall between edges) -> no grant, tx stays 1, busy 0.
REQ-031 Reset mid-frame: rst_n low at cycle 15 of a frame -> tx=1, busy=0 immediately; after release, req=10 -> grant=10 (no stale pointer issue), full 40-cycle frame.
REQ-032 Parity (TX_ARBITER_PARITY_EN defined): data=0x07 -> parity bit 1 at bit slot 9, frame 44 cycles; data=0x03 -> parity bit 0.
REQ-033 Data stability: change data[7:0] to 0xFF mid-frame after grant of 0x00 -> transmitted bits all 0 for that frame.

Source files
------------

// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: requester-side bus of tx_arbiter.
// req/data come from the requesters; grant/busy/tx come back from the arbiter.
// Modports: master = requester side, slave = arbiter side.
interface tx_arbiter_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] data;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 tx;
  modport master (output req, data, input grant, busy, tx);
  modport slave (input req, data, output grant, busy, tx);
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter that serialises requester bytes onto one UART-style line.
// Ports: clk, rst_n (async active-low), bus (tx_arbiter_if.slave):
//   req[NUM_REQ] level requests, data[NUM_REQ*8] bytes, grant one-hot accept pulse,
//   busy high during a frame, tx registered serial line idling high.
// Build option: define TX_ARBITER_PARITY_EN for 8E1 frames (even parity bit); default is 8N1.
module tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CLKS_PER_BIT = 4
) (
  input logic         clk,
  input logic         rst_n,
  tx_arbiter_if.slave bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef TX_ARBITER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] byte_q, byte_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic [PW-1:0] last, last_n, win;
  logic tx_q, tx_n, tick, accept;
  // First requester found scanning upward from the one after p, wrapping.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] w;
    w = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (r[(int'(p) + k) % NUM_REQ]) w = PW'((int'(p) + k) % NUM_REQ);
    return w;
  endfunction
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign win = rr_pick(bus.req, last);
  // Arbitration happens only while idle or on the final cycle of the stop bit.
  assign accept = |bus.req && (state == IDLE || (state == STOP && tick));
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || tick) ? '0 : cnt + CW'(1);
    bit_n = bit_idx;
    byte_n = byte_q;
    tx_n = tx_q;
    grant_n = '0;
    last_n = last;
    case (state)
      START: if (tick) begin
        state_n = DATA;
        bit_n = 3'd0;
        tx_n = byte_q[0];
      end
      DATA: if (tick) begin
        if (bit_idx == 3'd7) begin
`ifdef TX_ARBITER_PARITY_EN
          state_n = PARITY;
          tx_n = ^byte_q;
`else
          state_n = STOP;
          tx_n = 1'b1;
`endif
        end else begin
          bit_n = bit_idx + 3'd1;
          tx_n = byte_q[bit_n];
        end
      end
`ifdef TX_ARBITER_PARITY_EN
      PARITY: if (tick) begin
        state_n = STOP;
        tx_n = 1'b1;
      end
`endif
      STOP: if (tick) begin
        state_n = IDLE;
        tx_n = 1'b1;
      end
      default: ;
    endcase
    if (accept) begin
      state_n = START;
      tx_n = 1'b0;
      byte_n = bus.data[8*int'(win) +: 8];
      grant_n = NUM_REQ'(1) << win;
      last_n = win;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      byte_q <= '0;
      tx_q <= 1'b1;
      grant_q <= '0;
      last <= PW'(NUM_REQ - 1);
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      byte_q <= byte_n;
      tx_q <= tx_n;
      grant_q <= grant_n;
      last <= last_n;
    end
  end
  assign bus.grant = grant_q;
  assign bus.tx = tx_q;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: scoreboard bench for tx_arbiter with a frame-level reference model.
module tb_tx_arbiter;
  localparam int N = 2;
  localparam int CPB = 4;
`ifdef TX_ARBITER_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FL = NSLOT * CPB;
  typedef struct packed {logic [N-1:0] g; logic [7:0] b;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  tx_arbiter_if #(.NUM_REQ(N)) bus();
  tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  exp_t e_m, cur;
  int checks = 0, errors = 0, cyc = 0, free_edge = 0, last = N - 1, w_m, fpos = 0;
  logic [N-1:0] g_s;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic frame_bit(logic [7:0] b, int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == NSLOT - 1) return 1'b1;
    return ^b;
  endfunction
  // Reference model: the line is free FL edges after an accept; the winner is
  // the first requesting index after the last winner.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      free_edge = 0;
      last = N - 1;
    end else if (cyc >= free_edge && |bus.req) begin
      w_m = -1;
      for (int k = 1; k <= N; k++)
        if (w_m < 0 && bus.req[(last + k) % N]) w_m = (last + k) % N;
      e_m.g = N'(1) << w_m;
      e_m.b = bus.data[8*w_m +: 8];
      q.push_back(e_m);
      last = w_m;
      free_edge = cyc + FL;
    end
  end
  // Monitor: pops an expectation on each grant and checks the whole frame.
  always @(negedge clk) begin
    if (!rst_n) begin
      fpos = 0;
      q.delete();
      chk("reset_tx", 32'(bus.tx), 1);
      chk("reset_busy", 32'(bus.busy), 0);
      chk("reset_grant", 32'(bus.grant), 0);
    end else begin
      if (fpos == 0 && bus.grant != 0) begin
        if (q.size() == 0) chk("unexpected_grant", 32'(bus.grant), 0);
        else begin
          cur = q.pop_front();
          fpos = 1;
        end
      end
      if (fpos == 0) begin
        chk("idle_tx", 32'(bus.tx), 1);
        chk("idle_busy", 32'(bus.busy), 0);
        if (q.size() != 0) begin
          chk("missing_grant", 32'(bus.grant), 32'(q[0].g));
          q.delete();
        end
      end else begin
        chk("grant", 32'(bus.grant), fpos == 1 ? 32'(cur.g) : 0);
        chk("tx", 32'(bus.tx), 32'(frame_bit(cur.b, (fpos - 1) / CPB)));
        chk("busy", 32'(bus.busy), 1);
        fpos = fpos == FL ? 0 : fpos + 1;
      end
    end
  end
  task automatic send(int i, logic [7:0] b);
    bus.data[8*i +: 8] = b;
    bus.req[i] = 1'b1;
    for (int t = 0; t < 4 * FL; t++) begin
      @(negedge clk);
      if (bus.grant[i]) break;
    end
    chk("grant_wait", 32'(bus.grant[i]), 1);
    #1 bus.req[i] = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((bus.busy || q.size() != 0) && t < 10 * FL) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 32'(bus.busy), 0);
    @(negedge clk);
    #1;
  endtask
  initial begin
    bus.req = '0;
    bus.data = '0;
    #1 rst_n = 1'b0;
    #1 chk("por_tx", 32'(bus.tx), 1);
    chk("por_busy", 32'(bus.busy), 0);
    chk("por_grant", 32'(bus.grant), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    send(0, 8'hA5);
    wait_idle();
    bus.data = 16'h2211;
    bus.req = 2'b11;
    repeat (4 * FL) @(negedge clk);
    #1 bus.req = '0;
    wait_idle();
    bus.req[1] = 1'b1;
    #2 bus.req[1] = 1'b0;
    repeat (FL) @(negedge clk);
    chk("withdraw_busy", 32'(bus.busy), 0);
    chk("withdraw_tx", 32'(bus.tx), 1);
    #1 send(0, 8'hC3);
    repeat (14) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort_tx", 32'(bus.tx), 1);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_grant", 32'(bus.grant), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    send(1, 8'h5A);
    wait_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    bus.data = 16'h8877;
    bus.req = 2'b11;
    for (int t = 0; t < 10 && bus.grant == 0; t++) @(negedge clk);
    chk("post_reset_prio", 32'(bus.grant), 1);
    #1 bus.req = '0;
    wait_idle();
    send(0, 8'h00);
    repeat (9) @(negedge clk);
    #1 bus.data[7:0] = 8'hFF;
    wait_idle();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g_s = bus.grant;
      #1;
      for (int i = 0; i < N; i++) begin
        if (g_s[i]) bus.req[i] = 1'b0;
        else if (bus.req[i] && $urandom_range(0, 199) == 0) bus.req[i] = 1'b0;
        else if (!bus.req[i] && $urandom_range(0, 9) == 0) begin
          bus.data[8*i +: 8] = 8'($urandom);
          bus.req[i] = 1'b1;
        end
      end
    end
    bus.req = '0;
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
